// File: rtl/riscv_run_ctrl_pkg.sv
// Shared types and constants for the RV32I run controller.
package riscv_run_pkg;
  typedef enum logic [2:0] {ST_IDLE, ST_HOLD, ST_RUN, ST_DUMP, ST_DONE} run_state_e;
  typedef enum logic [1:0] {HC_NONE, HC_TIMEOUT, HC_EBREAK, HC_ECALL} halt_cause_e;

  localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;
  localparam logic [31:0] INSTR_ECALL  = 32'h0000_0073;
endpackage

// File: rtl/riscv_rf_dumper.sv
// Streams register indices 0..NREGS-1 over a valid/ready port, reading the core RF
// through its combinational debug port; pulses finish on the final handshake.
module riscv_rf_dumper
  import riscv_run_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  output logic            finish_o,
  output logic [4:0]      rf_addr_o,
  input  logic [XLEN-1:0] rf_rdata_i,
  output logic            dump_valid,
  input  logic            dump_ready,
  output logic [4:0]      dump_idx,
  output logic [XLEN-1:0] dump_data,
  output logic            dump_last
);
  logic       active_q, active_d;
  logic [4:0] idx_q, idx_d;
  logic       hs;

  assign hs        = active_q & dump_ready;
  assign dump_last = active_q & (idx_q == 5'(NREGS - 1));
  assign finish_o  = hs & dump_last;

  always_comb begin
    active_d = active_q;
    idx_d    = idx_q;
    if (start_i) begin
      active_d = 1'b1;
      idx_d    = '0;
    end else if (hs) begin
      if (dump_last) active_d = 1'b0;
      else           idx_d    = idx_q + 5'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active_q <= 1'b0;
      idx_q    <= '0;
    end else begin
      active_q <= active_d;
      idx_q    <= idx_d;
    end
  end

  assign dump_valid = active_q;
  assign dump_idx   = idx_q;
  assign rf_addr_o  = idx_q;
  assign dump_data  = active_q ? rf_rdata_i : '0;
endmodule

// File: rtl/riscv_run_ctrl.sv
// Run controller: imem load, core reset hold, budgeted run, register dump.
// Define RUN_CTRL_HALT_DETECT_EN to let a retired ECALL/EBREAK end the run early.
module riscv_run_ctrl
  import riscv_run_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int NREGS      = 32,
  parameter int IMEM_DEPTH = 256,
  parameter int MAX_CYCLES = 50,
  parameter int RST_HOLD   = 2,
  parameter int ADDR_W     = $clog2(IMEM_DEPTH),
  parameter int CNT_W      = $clog2(MAX_CYCLES + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [XLEN-1:0]   load_data,
  output logic              core_imem_we,
  output logic [ADDR_W-1:0] core_imem_addr,
  output logic [XLEN-1:0]   core_imem_wdata,
  output logic              core_rst_n,
  output logic              core_stall,
  input  logic              retire_valid,
  input  logic [XLEN-1:0]   retire_instr,
  output logic [4:0]        dbg_rf_addr,
  input  logic [XLEN-1:0]   dbg_rf_rdata,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [4:0]        dump_idx,
  output logic [XLEN-1:0]   dump_data,
  output logic              dump_last,
  output logic              busy,
  output logic              done,
  output logic [1:0]        halt_cause,
  output logic [CNT_W-1:0]  cycle_count
);
  localparam int HOLD_W = $clog2(RST_HOLD + 1);

  run_state_e         state_q, state_d;
  halt_cause_e        hc_q, hc_d, halt_sel;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic               halt_hit, dump_start, dump_finish;

`ifdef RUN_CTRL_HALT_DETECT_EN
  always_comb begin
    halt_hit = 1'b0;
    halt_sel = HC_NONE;
    if (retire_valid && retire_instr == XLEN'(INSTR_EBREAK)) begin
      halt_hit = 1'b1;
      halt_sel = HC_EBREAK;
    end else if (retire_valid && retire_instr == XLEN'(INSTR_ECALL)) begin
      halt_hit = 1'b1;
      halt_sel = HC_ECALL;
    end
  end
`else
  logic unused_retire;
  assign unused_retire = ^{retire_valid, retire_instr};
  assign halt_hit      = 1'b0;
  assign halt_sel      = HC_NONE;
`endif

  always_comb begin
    state_d    = state_q;
    hc_d       = hc_q;
    cnt_d      = cnt_q;
    hold_d     = hold_q;
    dump_start = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: if (start) begin
        state_d = ST_HOLD;
        hc_d    = HC_NONE;
        cnt_d   = '0;
        hold_d  = '0;
      end
      ST_HOLD: begin
        if (hold_q == HOLD_W'(RST_HOLD - 1)) state_d = ST_RUN;
        else                                 hold_d  = hold_q + HOLD_W'(1);
      end
      ST_RUN: begin
        cnt_d = cnt_q + CNT_W'(1);
        // a halt retiring on the budget's last cycle still reports the halt
        if (halt_hit) begin
          hc_d       = halt_sel;
          state_d    = ST_DUMP;
          dump_start = 1'b1;
        end else if (cnt_d == CNT_W'(MAX_CYCLES)) begin
          hc_d       = HC_TIMEOUT;
          state_d    = ST_DUMP;
          dump_start = 1'b1;
        end
      end
      ST_DUMP: if (dump_finish) state_d = ST_DONE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      hc_q    <= HC_NONE;
      cnt_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      hc_q    <= hc_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
    end
  end

  assign load_ready      = (state_q == ST_IDLE) || (state_q == ST_DONE);
  assign core_imem_we    = load_valid & load_ready;
  assign core_imem_addr  = core_imem_we ? load_addr : '0;
  assign core_imem_wdata = core_imem_we ? load_data : '0;
  // core keeps its reset released after the run so the dump sees live registers
  assign core_rst_n      = (state_q == ST_RUN) || (state_q == ST_DUMP) || (state_q == ST_DONE);
  assign core_stall      = (state_q != ST_RUN);
  assign busy            = (state_q == ST_HOLD) || (state_q == ST_RUN) || (state_q == ST_DUMP);
  assign done            = (state_q == ST_DONE);
  assign halt_cause      = hc_q;
  assign cycle_count     = cnt_q;

  riscv_rf_dumper #(.XLEN(XLEN), .NREGS(NREGS)) u_dumper (
    .clk        (clk),
    .rst        (rst),
    .start_i    (dump_start),
    .finish_o   (dump_finish),
    .rf_addr_o  (dbg_rf_addr),
    .rf_rdata_i (dbg_rf_rdata),
    .dump_valid (dump_valid),
    .dump_ready (dump_ready),
    .dump_idx   (dump_idx),
    .dump_data  (dump_data),
    .dump_last  (dump_last)
  );
endmodule

// File: tb/tb_riscv_run_ctrl.sv
// Directed bench for riscv_run_ctrl: load, timeout run, halt retire, dump, abort.
module tb_riscv_run_ctrl;
  logic        clk = 1'b0, rst, start, load_valid, load_ready;
  logic [7:0]  load_addr, core_imem_addr;
  logic [31:0] load_data, core_imem_wdata, retire_instr, dbg_rf_rdata, dump_data;
  logic        core_imem_we, core_rst_n, core_stall, retire_valid;
  logic [4:0]  dbg_rf_addr, dump_idx;
  logic        dump_valid, dump_ready, dump_last, busy, done;
  logic [1:0]  halt_cause;
  logic [5:0]  cycle_count;

  int n_chk = 0, n_err = 0;

  riscv_run_ctrl dut (
    .clk(clk), .rst(rst), .start(start),
    .load_valid(load_valid), .load_ready(load_ready), .load_addr(load_addr), .load_data(load_data),
    .core_imem_we(core_imem_we), .core_imem_addr(core_imem_addr), .core_imem_wdata(core_imem_wdata),
    .core_rst_n(core_rst_n), .core_stall(core_stall),
    .retire_valid(retire_valid), .retire_instr(retire_instr),
    .dbg_rf_addr(dbg_rf_addr), .dbg_rf_rdata(dbg_rf_rdata),
    .dump_valid(dump_valid), .dump_ready(dump_ready), .dump_idx(dump_idx),
    .dump_data(dump_data), .dump_last(dump_last),
    .busy(busy), .done(done), .halt_cause(halt_cause), .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rf_val(input logic [4:0] i);
    return (i == 5'd0) ? 32'h0 : 32'h1000_0000 + 32'(i) * 32'h0000_0101;
  endfunction
  assign dbg_rf_rdata = rf_val(dbg_rf_addr);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // leaves the bench inside RUN cycle 1
  task automatic start_run;
    start = 1'b1; tick; start = 1'b0;
    tick; tick;
  endtask

  task automatic wait_stop;
    int n = 0;
    while (!core_stall && n < 100) begin n++; tick; end
    chk("stop_bound", 32'(core_stall), 32'h1);
  endtask

  task automatic drain;
    int n = 0;
    dump_ready = 1'b1;
    while (!done && n < 100) begin
      if (dump_valid) n++;
      tick;
    end
    dump_ready = 1'b0;
    chk("drain_beats", 32'(n), 32'd32);
    chk("drain_done", 32'(done), 32'h1);
  endtask

  task automatic halt_at(input int cyc, input logic [31:0] instr);
    start_run;
    repeat (cyc - 1) tick;
    retire_valid = 1'b1; retire_instr = instr; tick;
    retire_valid = 1'b0; retire_instr = 32'h0;
  endtask

  logic [31:0] words [4] = '{32'h0050_0093, 32'h0010_8113, 32'h0010_0073, 32'h0000_0013};

  initial begin
    rst = 1'b1; start = 1'b0; load_valid = 1'b0; load_addr = '0; load_data = '0;
    retire_valid = 1'b0; retire_instr = '0; dump_ready = 1'b0;
    tick; tick;
    rst = 1'b0; #1;
    chk("rst_load_ready", 32'(load_ready), 32'h1);
    chk("rst_core_rst_n", 32'(core_rst_n), 32'h0);
    chk("rst_core_stall", 32'(core_stall), 32'h1);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_halt", 32'(halt_cause), 32'h0);
    chk("rst_cnt", 32'(cycle_count), 32'h0);
    chk("rst_dump_valid", 32'(dump_valid), 32'h0);
    chk("rst_we", 32'(core_imem_we), 32'h0);

    for (int i = 0; i < 4; i++) begin
      load_valid = 1'b1; load_addr = 8'(i); load_data = words[i]; #1;
      chk("load_we", 32'(core_imem_we), 32'h1);
      chk("load_addr", 32'(core_imem_addr), 32'(i));
      chk("load_data", core_imem_wdata, words[i]);
      tick;
    end

    // load and start together: write still lands, then HOLD
    load_addr = 8'd4; load_data = 32'h0000_0013; start = 1'b1; #1;
    chk("ld_start_we", 32'(core_imem_we), 32'h1);
    chk("ld_start_addr", 32'(core_imem_addr), 32'h4);
    tick; start = 1'b0; load_valid = 1'b0;
    chk("hold1_rst_n", 32'(core_rst_n), 32'h0);
    chk("hold1_ready", 32'(load_ready), 32'h0);
    chk("hold1_busy", 32'(busy), 32'h1);
    load_valid = 1'b1; #1;
    chk("hold_no_we", 32'(core_imem_we), 32'h0);
    load_valid = 1'b0;
    tick;
    chk("hold2_rst_n", 32'(core_rst_n), 32'h0);
    chk("hold2_stall", 32'(core_stall), 32'h1);
    tick;
    chk("run_rst_n", 32'(core_rst_n), 32'h1);
    begin
      int n = 0;
      while (!core_stall && n < 100) begin
        n++;
        start = (n == 5);
        tick;
        start = 1'b0;
      end
      chk("timeout_run_cycles", 32'(n), 32'd50);
    end
    chk("timeout_halt", 32'(halt_cause), 32'h1);
    chk("timeout_cnt", 32'(cycle_count), 32'd50);
    chk("dump_rst_n", 32'(core_rst_n), 32'h1);
    chk("dump_valid0", 32'(dump_valid), 32'h1);

    begin
      int beats = 0;
      logic rdy = 1'b1;
      for (int c = 0; c < 200 && beats < 32; c++) begin
        dump_ready = rdy; #1;
        if (dump_valid && dump_ready) begin
          chk("dump_idx", 32'(dump_idx), 32'(beats));
          chk("dump_data", dump_data, rf_val(5'(beats)));
          chk("dump_last", 32'(dump_last), 32'(beats == 31));
          beats++;
        end
        tick;
        rdy = ~rdy;
      end
      dump_ready = 1'b0;
      chk("dump_beats", 32'(beats), 32'd32);
    end
    chk("done_done", 32'(done), 32'h1);
    chk("done_busy", 32'(busy), 32'h0);
    chk("done_ready", 32'(load_ready), 32'h1);
    chk("done_valid", 32'(dump_valid), 32'h0);

    // EBREAK on run cycle 10, with a non-halt retire on cycle 5
    start_run;
    repeat (4) tick;
    retire_valid = 1'b1; retire_instr = 32'h0000_0013; tick;
    retire_valid = 1'b0;
    chk("nop_stall", 32'(core_stall), 32'h0);
    repeat (4) tick;
    retire_valid = 1'b1; retire_instr = 32'h0010_0073; tick;
    retire_valid = 1'b0; retire_instr = '0;
    chk("eb10_cnt", 32'(cycle_count), 32'd10);
`ifdef RUN_CTRL_HALT_DETECT_EN
    chk("eb10_stall", 32'(core_stall), 32'h1);
    chk("eb10_halt", 32'(halt_cause), 32'h2);
`else
    chk("eb10_stall", 32'(core_stall), 32'h0);
    wait_stop;
    chk("eb10_halt", 32'(halt_cause), 32'h1);
    chk("eb10_end_cnt", 32'(cycle_count), 32'd50);
`endif
    drain;

    halt_at(3, 32'h0000_0073);
    chk("ec3_cnt", 32'(cycle_count), 32'd3);
`ifdef RUN_CTRL_HALT_DETECT_EN
    chk("ec3_halt", 32'(halt_cause), 32'h3);
`else
    wait_stop;
    chk("ec3_halt", 32'(halt_cause), 32'h1);
`endif
    drain;

    halt_at(50, 32'h0010_0073);
    chk("eb50_cnt", 32'(cycle_count), 32'd50);
    chk("eb50_stall", 32'(core_stall), 32'h1);
`ifdef RUN_CTRL_HALT_DETECT_EN
    chk("eb50_halt", 32'(halt_cause), 32'h2);
`else
    chk("eb50_halt", 32'(halt_cause), 32'h1);
`endif
    drain;

    // abort mid-run
    start_run;
    repeat (19) tick;
    chk("pre_abort_cnt", 32'(cycle_count), 32'd19);
    rst = 1'b1; tick;
    chk("abort_rst_n", 32'(core_rst_n), 32'h0);
    chk("abort_stall", 32'(core_stall), 32'h1);
    chk("abort_cnt", 32'(cycle_count), 32'h0);
    chk("abort_busy", 32'(busy), 32'h0);
    chk("abort_halt", 32'(halt_cause), 32'h0);
    rst = 1'b0; tick;
    chk("abort_ready", 32'(load_ready), 32'h1);
    chk("abort_done", 32'(done), 32'h0);
    chk("abort_busy2", 32'(busy), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
